// File: rtl/seg_mux_if.sv
// Purpose: bus bundle between the clock datapath and the seven-segment scan driver.
// Signals:
//   load        1-cycle strobe capturing digits_in / dp_in / blink_mask
//   digits_in   packed BCD, digit k = [4k+3:4k], digit 0 rightmost
//   dp_in       decimal point per digit (1 = lit)
//   blink_mask  1 = digit blinks
//   blank_lz    live leading-zero blanking enable
//   seg         {a,b,c,d,e,f,g,dp}, active-low
//   an          anode enables, active-low, one-hot-low
//   frame_tick  1-cycle pulse at each frame start
interface seg_mux_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     blink_mask;
  logic                    blank_lz;
  logic [7:0]              seg;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_tick;

  modport master (
    output load, digits_in, dp_in, blink_mask, blank_lz,
    input  seg, an, frame_tick
  );

  modport slave (
    input  load, digits_in, dp_in, blink_mask, blank_lz,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg_mux_driver.sv
// Purpose: time-multiplexed N-digit seven-segment driver. Digits are latched into
// a pending buffer and swapped into the display only at frame wrap, so a frame
// never mixes old and new values. Each slot starts with a blank guard cycle.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   seg_mux_if.slave (load/digits_in/dp_in/blink_mask/blank_lz in;
//         seg/an/frame_tick out, all registered)
module seg_mux_driver #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic     clk,
  input  logic     rst,
  seg_mux_if.slave bus
);

  localparam int unsigned DW    = 4 * N_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                phase_q, phase_d;
  logic [DW-1:0]       disp_dig_q, disp_dig_d, pend_dig_q, pend_dig_d;
  logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0] disp_bm_q, disp_bm_d, pend_bm_q, pend_bm_d;
  logic                pend_valid_q, pend_valid_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                tick_q, tick_d;

  logic                last_slot_c, wrap_c;
  logic [N_DIGITS-1:0] lz_c;
  logic [3:0]          dig_c;

  // BCD to active-low {a..g}; 10..15 blank
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Scan counters, blink phase and load/swap path
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    blk_cnt_d    = blk_cnt_q;
    phase_d      = phase_q;
    disp_dig_d   = disp_dig_q;
    disp_dp_d    = disp_dp_q;
    disp_bm_d    = disp_bm_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_bm_d    = pend_bm_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;

    last_slot_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    wrap_c      = last_slot_c && (idx_q == IDX_W'(N_DIGITS - 1));

    if (last_slot_c) begin
      cnt_d = '0;
      idx_d = wrap_c ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (wrap_c) begin
      tick_d = 1'b1;
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end

    // A load on the wrap cycle bypasses pending and lands in the new frame
    if (bus.load && wrap_c) begin
      disp_dig_d   = bus.digits_in;
      disp_dp_d    = bus.dp_in;
      disp_bm_d    = bus.blink_mask;
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_dig_d   = bus.digits_in;
      pend_dp_d    = bus.dp_in;
      pend_bm_d    = bus.blink_mask;
      pend_valid_d = 1'b1;
    end else if (wrap_c && pend_valid_q) begin
      disp_dig_d   = pend_dig_q;
      disp_dp_d    = pend_dp_q;
      disp_bm_d    = pend_bm_q;
      pend_valid_d = 1'b0;
    end
  end

  // Leading-zero mask: digit k blanks when it and every digit above it are zero
  always_comb begin : lz_scan
    logic above_zero;
    above_zero = 1'b1;
    lz_c       = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      above_zero = above_zero && (disp_dig_d[4*k +: 4] == 4'd0);
      lz_c[k]    = above_zero && (k != 0) && bus.blank_lz;
    end
  end

  // Outputs are computed from next state so seg and an move on the same edge
  always_comb begin
    seg_d = 8'hFF;
    an_d  = '1;
    dig_c = 4'(disp_dig_d >> {idx_d, 2'b00});
    if (cnt_d != '0) begin
      an_d = ~(N_DIGITS'(1) << idx_d);
      if (!(phase_d && disp_bm_d[idx_d])) begin
        seg_d = {lz_c[idx_d] ? 7'h7F : dec7(dig_c), ~disp_dp_d[idx_d]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      phase_q      <= 1'b0;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      disp_bm_q    <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_bm_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      phase_q      <= phase_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      disp_bm_q    <= disp_bm_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_bm_q    <= pend_bm_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver with N_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// A position-based reference model (cycles since reset) predicts every output;
// directed scenarios add hand-computed literal expectations.
module tb_seg_mux_driver;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BF = 2;
  localparam int FR = N * R;

  localparam logic [6:0] SEGTAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seg_mux_if #(.N_DIGITS(N)) bus ();

  seg_mux_driver #(
    .N_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position p since reset gives slot, digit and frame directly
  int          mt;
  bit          mvalid;
  bit          mblz;
  logic [15:0] md, pd;
  logic [3:0]  mdp, mbm, pdp, pbm;
  bit          mpv;

  initial begin
    int          c, k, f, ph;
    logic [7:0]  es;
    logic [3:0]  ea;
    logic        et;
    logic [15:0] hi;
    mvalid = 0;
    mt = 0;
    md = '0; pd = '0; mdp = '0; mbm = '0; pdp = '0; pbm = '0; mpv = 0; mblz = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mt = 0; md = '0; pd = '0; mdp = '0; mbm = '0; pdp = '0; pbm = '0; mpv = 0;
        mvalid = 1;
      end else if (mvalid) begin
        mt++;
        if (bus.load) begin
          if (mt % FR == 0) begin
            md = bus.digits_in; mdp = bus.dp_in; mbm = bus.blink_mask; mpv = 0;
          end else begin
            pd = bus.digits_in; pdp = bus.dp_in; pbm = bus.blink_mask; mpv = 1;
          end
        end else if (mt % FR == 0 && mpv) begin
          md = pd; mdp = pdp; mbm = pbm; mpv = 0;
        end
      end
      mblz = bus.blank_lz;
      #1;
      if (mvalid) begin
        c  = mt % R;
        k  = (mt / R) % N;
        f  = mt / FR;
        ph = (f / BF) % 2;
        et = (mt % FR == 0) && (mt > 0);
        es = 8'hFF;
        ea = 4'hF;
        if (c != 0) begin
          ea = 4'hF & ~(4'b0001 << k);
          if (!(ph == 1 && mbm[k])) begin
            hi = md >> (4 * k);
            es = {(mblz && k != 0 && hi == 16'h0) ? 7'h7F : SEGTAB[md[4*k +: 4]], ~mdp[k]};
          end
        end
        chk("model_seg", {8'h0, bus.seg}, {8'h0, es});
        chk("model_an", {12'h0, bus.an}, {12'h0, ea});
        chk("model_tick", {15'h0, bus.frame_tick}, {15'h0, et});
      end
    end
  end

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_tick) begin
        seen = 1;
        break;
      end
    end
    chk("tick_seen", {15'h0, seen}, 16'h1);
  endtask

  // Called on the frame_tick cycle; checks all four slots, returns on next frame start
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    logic [3:0] ea;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      ea = 4'hF & ~(4'b0001 << s);
      chk({tag, "_an"}, {12'h0, bus.an}, {12'h0, ea});
      chk({tag, "_seg"}, {8'h0, bus.seg}, {8'h0, e[s]});
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
    bus.digits_in  = d;
    bus.dp_in      = dp;
    bus.blink_mask = bm;
    bus.load       = 1'b1;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  initial begin
    int         nblank0, nblank2;
    logic [7:0] s0 [4];
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
    bus.blink_mask = '0; bus.blank_lz = 1'b0;

    // Reset and first slot
    repeat (3) @(negedge clk);
    chk("rst_seg", {8'h0, bus.seg}, 16'h00FF);
    chk("rst_an", {12'h0, bus.an}, 16'h000F);
    chk("rst_tick", {15'h0, bus.frame_tick}, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_an", {12'h0, bus.an}, 16'h000E);
    chk("post_rst_seg", {8'h0, bus.seg}, 16'h0003);

    // Load 1234
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_tick();
    check_frame("f1234", 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);

    // Mid-frame load must not tear the current frame
    repeat (5) @(negedge clk);
    do_load(16'h5678, 4'b0000, 4'b0000);
    chk("no_tear_d1", {8'h0, bus.seg}, 16'h000D);
    repeat (7) @(negedge clk);
    chk("no_tear_d3", {8'h0, bus.seg}, 16'h009F);
    repeat (3) @(negedge clk);
    chk("tick_after_tear", {15'h0, bus.frame_tick}, 16'h1);
    check_frame("f5678", 8'h01, 8'h1F, 8'h41, 8'h49);

    // Load on the wrap cycle is visible in the new frame
    repeat (15) @(negedge clk);
    do_load(16'h4321, 4'b0000, 4'b0000);
    chk("wrap_load_tick", {15'h0, bus.frame_tick}, 16'h1);
    check_frame("f4321", 8'h9F, 8'h25, 8'h0D, 8'h99);

    // Leading-zero blanking with a decimal point on a blanked digit
    bus.blank_lz = 1'b1;
    do_load(16'h0070, 4'b0100, 4'b0000);
    wait_tick();
    check_frame("flz", 8'b00000011, 8'b00011111, 8'b11111110, 8'hFF);

    // Blink digits 0 and 1
    bus.blank_lz = 1'b0;
    do_load(16'h1234, 4'b0000, 4'b0011);
    wait_tick();
    nblank0 = 0; nblank2 = 0;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      s0[f] = bus.seg;
      if (bus.seg == 8'hFF) nblank0++;
      repeat (7) @(negedge clk);
      @(negedge clk);
      if (bus.seg == 8'hFF) nblank2++;
      repeat (7) @(negedge clk);
    end
    chk("blink_d0_count", 16'(nblank0), 16'd2);
    chk("blink_d2_steady", 16'(nblank2), 16'd0);
    chk("blink_d0_alt", {15'h0, (s0[0] != s0[2])}, 16'h1);

    // Reset mid-scan at idx 2
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", {8'h0, bus.seg}, 16'h00FF);
    chk("mid_rst_an", {12'h0, bus.an}, 16'h000F);
    chk("mid_rst_tick", {15'h0, bus.frame_tick}, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_an1", {12'h0, bus.an}, 16'h000E);
    chk("mid_rst_clr", {8'h0, bus.seg}, 16'h0003);

    // Codes above 9 blank
    do_load(16'h000C, 4'b0000, 4'b0000);
    wait_tick();
    @(negedge clk);
    chk("code_c_an", {12'h0, bus.an}, 16'h000E);
    chk("code_c_seg", {8'h0, bus.seg}, 16'h00FF);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
